wrr_arbiter: RTL

- Parametrised, registered weighted round-robin arbiter; successor to the basic N-way arbiter.
- Adds per-requester burst weights, grant lock (hold), and a runtime-selectable fixed-priority mode.
- Sits in front of shared resources (bus ports, memory banks, FIFO write ports) where fairness and burst ownership matter.

---
 rtl/wrr_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/wrr_arbiter.sv
// Registered weighted round-robin arbiter with per-requester burst weights,
// grant lock and a runtime-selectable fixed-priority mode.
module wrr_arbiter #(
  parameter int N     = 4,
  parameter int W     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N*W-1:0]     weight,
  input  logic [N-1:0]       lock,
  input  logic               mode,
  output logic [N-1:0]       grant,
  output logic               valid_grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] r_owner;
  logic             r_valid;
  logic [W-1:0]     r_credit;
  logic [IDX_W-1:0] r_ptr;
  logic [N-1:0]     r_grant;

  logic             w_hold;
  logic             w_found;
  logic [IDX_W-1:0] w_win;
  logic [IDX_W-1:0] w_base;
  int               w_cand;
  logic [W-1:0]     w_wsel;
  logic [IDX_W-1:0] w_owner_nxt;
  logic             w_valid_nxt;
  logic [W-1:0]     w_credit_nxt;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [N-1:0]     w_grant_nxt;

  // Winner search: circular scan from ptr in round-robin mode, from 0 in fixed-priority mode
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = 0;
    if (mode) begin
      w_base = '0;
    end else begin
      w_base = r_ptr;
    end
    for (int k = 0; k < N; k++) begin
      w_cand = (int'(w_base) + k) % N;
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(w_cand);
      end else begin
        w_found = w_found;
      end
    end
    w_wsel = weight[int'(w_win)*W +: W];
  end

  // Next-state: hold the current burst/lock, otherwise arbitrate
  always_comb begin
    w_hold       = r_valid && req[r_owner] && (lock[r_owner] || (r_credit != '0));
    w_owner_nxt  = r_owner;
    w_valid_nxt  = r_valid;
    w_credit_nxt = r_credit;
    w_ptr_nxt    = r_ptr;
    w_grant_nxt  = '0;
    if (w_hold) begin
      // A locked owner keeps whatever credit is left for after the lock drops
      if (!lock[r_owner]) begin
        w_credit_nxt = r_credit - W'(1);
      end else begin
        w_credit_nxt = r_credit;
      end
    end else if (w_found) begin
      w_owner_nxt  = w_win;
      w_valid_nxt  = 1'b1;
      w_credit_nxt = (w_wsel == '0) ? '0 : (w_wsel - W'(1));
      w_ptr_nxt    = IDX_W'((int'(w_win) + 1) % N);
    end else begin
      w_owner_nxt  = '0;
      w_valid_nxt  = 1'b0;
      w_credit_nxt = '0;
    end
    if (w_valid_nxt) begin
      w_grant_nxt[w_owner_nxt] = 1'b1;
    end else begin
      w_grant_nxt = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner  <= '0;
      r_valid  <= 1'b0;
      r_credit <= '0;
      r_ptr    <= '0;
      r_grant  <= '0;
    end else begin
      r_owner  <= w_owner_nxt;
      r_valid  <= w_valid_nxt;
      r_credit <= w_credit_nxt;
      r_ptr    <= w_ptr_nxt;
      r_grant  <= w_grant_nxt;
    end
  end

  assign grant       = r_grant;
  assign valid_grant = r_valid;
  assign grant_idx   = r_owner;

endmodule
